// File: rtl/boot_load_sequencer_pkg.sv
// Shared definitions for the boot load sequencer: FSM state encoding and
// the loader address helper.
package boot_load_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Loader write address; the 16-bit sum wraps 16'hFFFF -> 16'h0000.
    function automatic logic [15:0] wrap_adrs(input logic [15:0] base,
                                              input logic [15:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/boot_bus_mux.sv
// Combinational owner-select of the shared memory port: the loader owns it
// in LOAD, the core owns it in RUN, and nobody drives strobes otherwise.
module boot_bus_mux
    import boot_load_sequencer_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ld_adrs,
    input  logic [15:0] ld_wdata,
    input  logic        ld_wr,
    input  logic [15:0] cpu_adrs,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] mem_adrs,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr
);

    // Route address, data and strobes from the current port owner.
    always_comb begin
        mem_adrs  = 16'h0000;
        mem_wdata = 16'h0000;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            ST_LOAD: begin
                mem_adrs  = ld_adrs;
                mem_wdata = ld_wdata;
                mem_wr    = ld_wr;
            end
            ST_RUN: begin
                mem_adrs  = cpu_adrs;
                mem_wdata = cpu_wdata;
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
            end
            default: begin
                mem_adrs  = 16'h0000;
                mem_wdata = 16'h0000;
                mem_rd    = 1'b0;
                mem_wr    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/boot_load_sequencer.sv
// Boot load sequencer: holds the core in reset while a program image is
// streamed into memory, then releases the core and hands it the memory port.
module boot_load_sequencer
    import boot_load_sequencer_pkg::*;
#(
    parameter logic [15:0] BASE_ADRS  = 16'h0000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_start,
    input  logic [15:0] load_len,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic        cpu_reset,
    input  logic [15:0] cpu_adrs,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] cpu_rdata,
    output logic [15:0] mem_adrs,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] count_r;
    logic [15:0] len_r;
    logic [3:0]  rst_cnt_r;
    logic        cpu_reset_r;
    logic        busy_r;
    logic        done_r;
    logic        word_accept_s;
    logic        last_word_s;
    logic        rst_done_s;
    logic        start_ok_s;

    assign wr_ready      = (state_r == ST_LOAD);
    assign word_accept_s = wr_valid & wr_ready;
    assign last_word_s   = (count_r == (len_r - 16'd1));
    assign rst_done_s    = (rst_cnt_r == RST_LAST);
    // A new load/boot request is honoured only while idle or running.
    assign start_ok_s    = load_start & ((state_r == ST_HOLD) | (state_r == ST_RUN));

    assign cpu_rdata = mem_rdata;
    assign cpu_reset = cpu_reset_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_HOLD, ST_RUN: begin
                if (load_start) begin
                    next_state_s = (load_len != 16'd0) ? ST_LOAD : ST_RELEASE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (word_accept_s && last_word_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                if (rst_done_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_RELEASE;
                end
            end
            default: next_state_s = ST_HOLD;
        endcase
    end

    // Word counter, latched length and release-delay counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r   <= 16'd0;
            len_r     <= 16'd0;
            rst_cnt_r <= 4'd0;
        end else begin
            if (start_ok_s) begin
                count_r <= 16'd0;
                len_r   <= load_len;
            end else if (word_accept_s) begin
                count_r <= count_r + 16'd1;
            end
            if ((state_r == ST_RELEASE) && !rst_done_s) begin
                rst_cnt_r <= rst_cnt_r + 4'd1;
            end else begin
                rst_cnt_r <= 4'd0;
            end
        end
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_reset_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cpu_reset_r <= (next_state_s != ST_RUN);
            busy_r      <= (next_state_s == ST_LOAD) || (next_state_s == ST_RELEASE);
            done_r      <= (next_state_s == ST_RUN) && (state_r != ST_RUN);
        end
    end

    boot_bus_mux u_bus_mux (
        .state     (state_r),
        .ld_adrs   (wrap_adrs(BASE_ADRS, count_r)),
        .ld_wdata  (wr_data),
        .ld_wr     (word_accept_s),
        .cpu_adrs  (cpu_adrs),
        .cpu_wdata (cpu_wdata),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .mem_adrs  (mem_adrs),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr)
    );

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Directed bench for boot_load_sequencer: instance a uses BASE_ADRS=0,
// instance b uses BASE_ADRS=16'hFFFE to exercise address wrap.
module tb_boot_load_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad   = 0;

    logic        load_start, wr_valid, cpu_rd, cpu_wr;
    logic [15:0] load_len, wr_data, cpu_adrs, cpu_wdata, mem_rdata;
    logic        wr_ready, cpu_reset, mem_rd, mem_wr, busy, done;
    logic [15:0] cpu_rdata, mem_adrs, mem_wdata;

    logic        b_load_start, b_wr_valid;
    logic [15:0] b_load_len, b_wr_data;
    logic        b_wr_ready, b_cpu_reset, b_mem_rd, b_mem_wr, b_busy, b_done;
    logic [15:0] b_cpu_rdata, b_mem_adrs, b_mem_wdata;

    always #5 clock = ~clock;

    boot_load_sequencer u_dut (
        .clock(clock), .reset(reset), .load_start(load_start), .load_len(load_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .cpu_reset(cpu_reset), .cpu_adrs(cpu_adrs), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
        .mem_adrs(mem_adrs), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done)
    );

    boot_load_sequencer #(.BASE_ADRS(16'hFFFE), .RST_CYCLES(2)) u_dut_b (
        .clock(clock), .reset(reset), .load_start(b_load_start), .load_len(b_load_len),
        .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .cpu_reset(b_cpu_reset), .cpu_adrs(16'h0000), .cpu_wdata(16'h0000),
        .cpu_rd(1'b0), .cpu_wr(1'b0), .cpu_rdata(b_cpu_rdata),
        .mem_adrs(b_mem_adrs), .mem_wdata(b_mem_wdata), .mem_rdata(16'h0000),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    logic [15:0] exp_b [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [5:0]  pat = 6'b101001;
    int          idx;
    int          nwr;

    initial begin
        reset = 1'b1; load_start = 1'b0; load_len = 16'd0; wr_valid = 1'b0; wr_data = 16'd0;
        cpu_adrs = 16'd0; cpu_wdata = 16'd0; cpu_rd = 1'b0; cpu_wr = 1'b0; mem_rdata = 16'd0;
        b_load_start = 1'b0; b_load_len = 16'd0; b_wr_valid = 1'b0; b_wr_data = 16'd0;
        tick(); tick();
        reset = 1'b0;

        // Idle in HOLD after reset
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk("idle_cpu_reset", cpu_reset, 16'd1);
            chk("idle_mem_wr", mem_wr, 16'd0);
            chk("idle_wr_ready", wr_ready, 16'd0);
            chk("idle_busy", busy, 16'd0);
            chk("idle_done", done, 16'd0);
        end

        // Continuous 3-word load
        tick(); load_start = 1'b1; load_len = 16'd3; #1;
        chk("start_wr_ready", wr_ready, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); load_start = 1'b0; wr_valid = 1'b1; wr_data = 16'hA001 + 16'(i); #1;
            chk("c_mem_wr", mem_wr, 16'd1);
            chk("c_mem_adrs", mem_adrs, 16'(i));
            chk("c_mem_wdata", mem_wdata, 16'hA001 + 16'(i));
            chk("c_busy", busy, 16'd1);
            chk("c_cpu_reset", cpu_reset, 16'd1);
        end
        tick(); wr_valid = 1'b0; #1;
        chk("rel1_mem_wr", mem_wr, 16'd0);
        chk("rel1_wr_ready", wr_ready, 16'd0);
        chk("rel1_cpu_reset", cpu_reset, 16'd1);
        chk("rel1_busy", busy, 16'd1);
        chk("rel1_done", done, 16'd0);
        tick(); #1;
        chk("rel2_cpu_reset", cpu_reset, 16'd1);
        chk("rel2_done", done, 16'd0);
        tick(); #1;
        chk("run_cpu_reset", cpu_reset, 16'd0);
        chk("run_done", done, 16'd1);
        chk("run_busy", busy, 16'd0);

        // Transparent core path
        tick(); cpu_adrs = 16'h0010; cpu_wr = 1'b1; cpu_wdata = 16'h55AA; mem_rdata = 16'h1234; #1;
        chk("run_done_once", done, 16'd0);
        chk("pass_adrs", mem_adrs, 16'h0010);
        chk("pass_wr", mem_wr, 16'd1);
        chk("pass_wdata", mem_wdata, 16'h55AA);
        chk("pass_rd0", mem_rd, 16'd0);
        chk("pass_rdata", cpu_rdata, 16'h1234);
        tick(); cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_adrs = 16'h0020; #1;
        chk("pass_rd1", mem_rd, 16'd1);
        chk("pass_adrs2", mem_adrs, 16'h0020);
        chk("pass_wr0", mem_wr, 16'd0);

        // Re-load from RUN with gapped wr_valid; core keeps requesting writes
        tick(); cpu_rd = 1'b0; cpu_wr = 1'b1; load_start = 1'b1; load_len = 16'd3; #1;
        chk("reload_same_cycle_wr", mem_wr, 16'd1);
        chk("reload_same_cycle_rst", cpu_reset, 16'd0);
        idx = 0; nwr = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); load_start = 1'b0; wr_valid = pat[i]; wr_data = 16'hB000 + 16'(idx); #1;
            chk("g_cpu_reset", cpu_reset, 16'd1);
            chk("g_mem_wr", mem_wr, 16'(pat[i]));
            if (mem_wr) nwr++;
            if (pat[i]) begin
                chk("g_mem_adrs", mem_adrs, 16'(idx));
                chk("g_mem_wdata", mem_wdata, 16'hB000 + 16'(idx));
                idx++;
            end
        end
        chk("g_write_count", 16'(nwr), 16'd3);
        tick(); wr_valid = 1'b0; #1;
        chk("g_rel_busy", busy, 16'd1);
        chk("g_rel_core_dropped", mem_wr, 16'd0);
        tick(); #1;
        chk("g_rel2_cpu_reset", cpu_reset, 16'd1);
        tick(); #1;
        chk("g_run_done", done, 16'd1);
        chk("g_run_cpu_reset", cpu_reset, 16'd0);
        chk("g_run_core_wr", mem_wr, 16'd1);

        // Reset after 2 of 5 words, together with load_start
        tick(); cpu_wr = 1'b0; load_start = 1'b1; load_len = 16'd5;
        for (int i = 0; i < 2; i++) begin
            tick(); load_start = 1'b0; wr_valid = 1'b1; wr_data = 16'hD000 + 16'(i); #1;
            chk("p_mem_adrs", mem_adrs, 16'(i));
        end
        tick(); wr_valid = 1'b0; reset = 1'b1; load_start = 1'b1; load_len = 16'd3; #1;
        chk("p_stall_wr", mem_wr, 16'd0);
        tick(); reset = 1'b0; load_start = 1'b0; #1;
        chk("rst_wr_ready", wr_ready, 16'd0);
        chk("rst_busy", busy, 16'd0);
        chk("rst_cpu_reset", cpu_reset, 16'd1);
        tick(); #1;
        chk("rst_hold_busy", busy, 16'd0);

        // Zero-length boot of existing image
        tick(); load_start = 1'b1; load_len = 16'd0; wr_valid = 1'b1; wr_data = 16'hEEEE; #1;
        chk("z_hold_wr", mem_wr, 16'd0);
        tick(); load_start = 1'b0; #1;
        chk("z_rel_wr", mem_wr, 16'd0);
        chk("z_rel_busy", busy, 16'd1);
        chk("z_rel_wr_ready", wr_ready, 16'd0);
        tick(); #1;
        chk("z_rel2_wr", mem_wr, 16'd0);
        chk("z_rel2_cpu_reset", cpu_reset, 16'd1);
        tick(); wr_valid = 1'b0; #1;
        chk("z_run_cpu_reset", cpu_reset, 16'd0);
        chk("z_run_done", done, 16'd1);

        // Address wrap on instance b
        tick(); b_load_start = 1'b1; b_load_len = 16'd4;
        for (int i = 0; i < 4; i++) begin
            tick(); b_load_start = 1'b0; b_wr_valid = 1'b1; b_wr_data = 16'hC000 + 16'(i); #1;
            chk("w_mem_wr", b_mem_wr, 16'd1);
            chk("w_mem_adrs", b_mem_adrs, exp_b[i]);
            chk("w_mem_wdata", b_mem_wdata, 16'hC000 + 16'(i));
        end
        tick(); b_wr_valid = 1'b0; #1;
        chk("w_rel_busy", b_busy, 16'd1);
        chk("w_rel_wr", b_mem_wr, 16'd0);
        tick(); tick(); #1;
        chk("w_run_done", b_done, 16'd1);
        chk("w_run_cpu_reset", b_cpu_reset, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_load_sequencer.md
Name: boot_load_sequencer

Overview:
- Sequences start-up of the 16-bit microprocessor core.
- Holds the core in reset while an external word stream (host or UART bridge) writes a program image into the shared single-port memory.
- Then releases the core and hands the memory port over to it.
- Sits between the core's memory interface (adrs_bus/data_out/data_in/mem_rd/mem_wr) and the memory. It owns the core's reset and the memory-port mux.

Parameters:
- BASE_ADRS, 16'h0000: memory address of the first loaded word.
- RST_CYCLES, 2: cycles cpu_reset stays high after the load completes (range 1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle request to begin a load/boot sequence
- load_len  in  16  number of words to load, sampled with load_start
- wr_valid  in  1  loader word valid
- wr_data  in  16  loader word
- wr_ready  out  1  loader word accepted this cycle when wr_valid is also high
- cpu_reset  out  1  drives the core's reset input
- cpu_adrs  in  16  core address bus
- cpu_wdata  in  16  core write data
- cpu_rd  in  1  core memory read
- cpu_wr  in  1  core memory write
- cpu_rdata  out  16  read data returned to the core
- mem_adrs  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- busy  out  1  high in LOAD or RELEASE
- done  out  1  one-cycle pulse on entry to RUN

Behaviour:
- One clock. Reset is synchronous and active-high on port "reset"; clock port is "clock".
- Reset state is HOLD, with count=0 and rst_cnt=0.
- Outputs while in reset or HOLD: cpu_reset=1, wr_ready=0, busy=0, done=0, mem_rd=0, mem_wr=0.
- States: HOLD, LOAD, RELEASE, RUN.
- HOLD:
  - load_start with load_len!=0: latch len, count=0, go to LOAD.
  - load_start with load_len==0: go to RELEASE (boot existing memory image).
- LOAD:
  - wr_ready=1.
  - A word is accepted when wr_valid&wr_ready. In the same cycle: mem_wr=1, mem_adrs=BASE_ADRS+count (mod 2^16, wraps 16'hFFFF->16'h0000), mem_wdata=wr_data. The write is combinational, zero latency.
  - count increments on each accepted word.
  - When the word with count==len-1 is accepted, go to RELEASE next cycle.
  - wr_valid low: no write, no count change (stall indefinitely).
  - load_start is ignored in LOAD.
- RELEASE:
  - cpu_reset=1, wr_ready=0, mem strobes 0.
  - rst_cnt counts from 0; after exactly RST_CYCLES cycles in RELEASE, go to RUN.
- RUN:
  - cpu_reset=0, wr_ready=0, busy=0.
  - Transparent path: mem_adrs=cpu_adrs, mem_wdata=cpu_wdata, mem_rd=cpu_rd, mem_wr=cpu_wr.
  - done=1 for the first RUN cycle only.
- cpu_rdata=mem_rdata in every state. It is only meaningful in RUN.
- load_start in RUN: core is re-held, with cpu_reset=1 from the next cycle. Core bus requests are dropped from that cycle on. Transition follows the HOLD rules (LOAD, or RELEASE if load_len==0).
- Simultaneous reset and load_start: reset wins; state is HOLD.
- Reset mid-LOAD: partial image is left in memory, state returns to HOLD, count cleared.
- All state and the cpu_reset output are registered. wr_ready and the mem_* outputs are combinational from state and inputs.

Decomposition:
- Shared package/include: 2-bit state encodings (ST_HOLD=0, ST_LOAD=1, ST_RELEASE=2, ST_RUN=3).
- Sub-module: boot_bus_mux. It is the combinational owner-select of mem_adrs/mem_wdata/mem_rd/mem_wr between the loader and the core, selected by state.
- The FSM, count and rst_cnt stay in the top module.

Test Plan:
- Reset then idle 10 cycles -> cpu_reset=1, mem_wr=0, wr_ready=0, busy=0 throughout.
- load_start, load_len=3, words 16'hA001/16'hA002/16'hA003 with wr_valid continuous -> writes at 0x0000/0x0001/0x0002 on three consecutive cycles. cpu_reset stays 1 for 2 more cycles, then 0. done pulses once.
- Same load with wr_valid gapped (1,0,0,1,0,1) -> exactly 3 writes, addresses contiguous, no write while wr_valid=0.
- BASE_ADRS=16'hFFFE, load_len=4 -> writes at FFFE, FFFF, 0000, 0001.
- In RUN, drive cpu_adrs=16'h0010, cpu_wr=1, cpu_wdata=16'h55AA -> mem_adrs=0010, mem_wr=1, mem_wdata=55AA. Drive mem_rdata=16'h1234 -> cpu_rdata=1234.
- Assert reset after 2 of 5 words loaded -> HOLD next cycle, count=0, wr_ready=0. A following load_start with load_len=0 -> RELEASE, then RUN after 2 cycles with no memory writes.
